// File: rtl/word_blinker.sv
// Frame-synchronous blink gate for a word overlay layer: ON/OFF periods counted in frames.
// Latency: drawWordOut/RGBWordOut/done are registered (1 cycle); busy is combinational from state.
// Backpressure: none; every input is a single-cycle pulse or a per-pixel level, and the block never stalls.
package word_blinker_defs_pkg;
    localparam logic [7:0] COLOR_TRANSPARENT = 8'hFF;
endpackage

module word_blinker
    import word_blinker_defs_pkg::*;
#(
    parameter int unsigned ON_FRAMES   = 30,
    parameter int unsigned OFF_FRAMES  = 15,
    parameter int unsigned BLINK_COUNT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       trigger,
    input  logic       stop,
    input  logic       drawWord,
    input  logic [7:0] RGBWord,
    output logic       drawWordOut,
    output logic [7:0] RGBWordOut,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_ON   = 2'd2,
        S_OFF  = 2'd3
    } state_t;

    localparam logic [7:0] ON_LAST    = 8'(ON_FRAMES - 1);
    localparam logic [7:0] OFF_LAST   = 8'(OFF_FRAMES - 1);
    localparam logic [3:0] BLINK_LAST = 4'(BLINK_COUNT - 1);
    localparam bit         FINITE     = (BLINK_COUNT != 0);

    state_t     state, state_nxt;
    logic [7:0] frame_cnt, frame_nxt;
    logic [3:0] blink_cnt, blink_nxt;
    logic       done_nxt;
    logic       gate;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            frame_cnt   <= 8'd0;
            blink_cnt   <= 4'd0;
            done        <= 1'b0;
            drawWordOut <= 1'b0;
            RGBWordOut  <= COLOR_TRANSPARENT;
        end else begin
            state       <= state_nxt;
            frame_cnt   <= frame_nxt;
            blink_cnt   <= blink_nxt;
            done        <= done_nxt;
            drawWordOut <= gate;
            RGBWordOut  <= gate ? RGBWord : COLOR_TRANSPARENT;
        end
    end

    always_comb begin
        state_nxt = state;
        frame_nxt = frame_cnt;
        blink_nxt = blink_cnt;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                // stop alongside trigger cancels the request
                if (trigger && !stop) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    frame_nxt = 8'd0;
                    blink_nxt = 4'd0;
                end else if (startOfFrame) begin
                    state_nxt = S_ON;
                    frame_nxt = 8'd0;
                    blink_nxt = 4'd0;
                end
            end
            S_ON: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    frame_nxt = 8'd0;
                    blink_nxt = 4'd0;
                end else if (startOfFrame) begin
                    if (frame_cnt == ON_LAST) begin
                        state_nxt = S_OFF;
                        frame_nxt = 8'd0;
                    end else begin
                        frame_nxt = frame_cnt + 8'd1;
                    end
                end
            end
            S_OFF: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    frame_nxt = 8'd0;
                    blink_nxt = 4'd0;
                end else if (startOfFrame) begin
                    if (frame_cnt == OFF_LAST) begin
                        frame_nxt = 8'd0;
                        if (FINITE && blink_cnt == BLINK_LAST) begin
                            state_nxt = S_IDLE;
                            blink_nxt = 4'd0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_ON;
                            blink_nxt = FINITE ? blink_cnt + 4'd1 : 4'd0;
                        end
                    end else begin
                        frame_nxt = frame_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                frame_nxt = 8'd0;
                blink_nxt = 4'd0;
            end
        endcase
    end

    assign gate = drawWord && (state == S_ON);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_word_blinker.sv
// Bench for word_blinker: fixed vector table, directed corner sequences and random traffic vs a frame-index model.
module tb_word_blinker;
    import word_blinker_defs_pkg::*;

    localparam int ON_F  = 2;
    localparam int OFF_F = 1;
    localparam int PER   = ON_F + OFF_F;
    localparam logic [7:0] TR = COLOR_TRANSPARENT;

    logic       clk = 1'b0;
    logic       reset, sof, trigger, stop, draw;
    logic [7:0] rgb;

    logic       d1_draw, d1_busy, d1_done;
    logic [7:0] d1_rgb;
    logic       d0_draw, d0_busy, d0_done;
    logic [7:0] d0_rgb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    word_blinker #(.ON_FRAMES(ON_F), .OFF_FRAMES(OFF_F), .BLINK_COUNT(2)) dut1 (
        .clk(clk), .reset(reset), .startOfFrame(sof), .trigger(trigger), .stop(stop),
        .drawWord(draw), .RGBWord(rgb),
        .drawWordOut(d1_draw), .RGBWordOut(d1_rgb), .busy(d1_busy), .done(d1_done)
    );

    word_blinker #(.ON_FRAMES(ON_F), .OFF_FRAMES(OFF_F), .BLINK_COUNT(0)) dut0 (
        .clk(clk), .reset(reset), .startOfFrame(sof), .trigger(trigger), .stop(stop),
        .drawWord(draw), .RGBWord(rgb),
        .drawWordOut(d0_draw), .RGBWordOut(d0_rgb), .busy(d0_busy), .done(d0_done)
    );

    // Model: a run is "frame f since the first frame boundary after trigger"; visible when f mod PER < ON_F.
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2;
    typedef struct {
        int         mode;
        int         f;
        logic       draw_out;
        logic [7:0] rgb_out;
        logic       done;
    } model_t;

    model_t m1, m0;

    function automatic model_t mnext(model_t m, int blinks, logic r, logic t, logic s,
                                     logic fr, logic d, logic [7:0] c);
        model_t n;
        logic vis;
        n = m;
        vis = (m.mode == M_RUN) && ((m.f % PER) < ON_F);
        n.draw_out = d && vis;
        n.rgb_out  = (d && vis) ? c : TR;
        n.done     = 1'b0;
        if (r) begin
            n.mode = M_IDLE; n.f = 0; n.draw_out = 1'b0; n.rgb_out = TR;
        end else if (s && m.mode != M_IDLE) begin
            n.mode = M_IDLE; n.f = 0;
        end else if (m.mode == M_IDLE) begin
            if (t && !s) n.mode = M_ARMED;
        end else if (m.mode == M_ARMED) begin
            if (fr) begin n.mode = M_RUN; n.f = 0; end
        end else if (fr) begin
            if (blinks != 0 && m.f + 1 == blinks * PER) begin
                n.mode = M_IDLE; n.f = 0; n.done = 1'b1;
            end else begin
                n.f = (blinks == 0) ? (m.f + 1) % PER : m.f + 1;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic t, input logic s, input logic fr,
                       input logic d, input logic [7:0] c);
        reset = r; trigger = t; stop = s; sof = fr; draw = d; rgb = c;
        @(posedge clk);
        m1 = mnext(m1, 2, r, t, s, fr, d, c);
        m0 = mnext(m0, 0, r, t, s, fr, d, c);
        #1;
        check("b2_draw", {7'd0, d1_draw}, {7'd0, m1.draw_out});
        check("b2_rgb",  d1_rgb, m1.rgb_out);
        check("b2_busy", {7'd0, d1_busy}, {7'd0, m1.mode != M_IDLE});
        check("b2_done", {7'd0, d1_done}, {7'd0, m1.done});
        check("b0_draw", {7'd0, d0_draw}, {7'd0, m0.draw_out});
        check("b0_rgb",  d0_rgb, m0.rgb_out);
        check("b0_busy", {7'd0, d0_busy}, {7'd0, m0.mode != M_IDLE});
        check("b0_done", {7'd0, d0_done}, {7'd0, m0.done});
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C);
    endtask

    task automatic frame(input logic t, input logic s);
        cyc(1'b0, t, s, 1'b1, 1'b1, 8'h1C);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C);
    endtask

    typedef struct packed {
        logic       r, t, s, fr;
        logic       e_draw;
        logic [7:0] e_rgb;
        logic       e_busy, e_done;
    } vec_t;

    vec_t tbl [16];

    initial begin
        m1 = '{M_IDLE, 0, 1'b0, TR, 1'b0};
        m0 = '{M_IDLE, 0, 1'b0, TR, 1'b0};
        reset = 1'b1; trigger = 1'b0; stop = 1'b0; sof = 1'b0; draw = 1'b0; rgb = 8'h00;

        // Seven frame boundaries on alternate cycles, word always drawn in 8'h1C.
        tbl[0]  = '{1, 0, 0, 0, 0, TR,    0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, TR,    1, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, TR,    1, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 8'h1C, 1, 0};
        tbl[4]  = '{0, 0, 0, 1, 1, 8'h1C, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 8'h1C, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 1, 8'h1C, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, TR,    1, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, TR,    1, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 8'h1C, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 1, 8'h1C, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 8'h1C, 1, 0};
        tbl[12] = '{0, 0, 0, 1, 1, 8'h1C, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0, TR,    1, 0};
        tbl[14] = '{0, 0, 0, 1, 0, TR,    0, 1};
        tbl[15] = '{0, 0, 0, 0, 0, TR,    0, 0};

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].fr, 1'b1, 8'h1C);
            check("tbl_draw", {7'd0, d1_draw}, {7'd0, tbl[i].e_draw});
            check("tbl_rgb",  d1_rgb, tbl[i].e_rgb);
            check("tbl_busy", {7'd0, d1_busy}, {7'd0, tbl[i].e_busy});
            check("tbl_done", {7'd0, d1_done}, {7'd0, tbl[i].e_done});
        end

        // Stop in the second ON frame.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C);
        check("stop_busy", {7'd0, d1_busy}, 8'd0);
        idle_cyc(1);
        check("stop_draw", {7'd0, d1_draw}, 8'd0);
        check("stop_done", {7'd0, d1_done}, 8'd0);

        // Trigger while OFF is ignored; run still ends after seven frames.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C);
        check("offtrig_draw", {7'd0, d1_draw}, 8'd0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1C);
        check("offtrig_done", {7'd0, d1_done}, 8'd1);
        check("offtrig_busy", {7'd0, d1_busy}, 8'd0);
        idle_cyc(2);

        // Stop together with a frame boundary at the last ON frame.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1C);
        check("stopsof_busy", {7'd0, d1_busy}, 8'd0);
        idle_cyc(2);

        // Trigger with stop in IDLE stays idle.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C);
        check("trigstop_busy", {7'd0, d1_busy}, 8'd0);

        // Reset in OFF, then a full fresh run.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C);
        check("rst_busy", {7'd0, d1_busy}, 8'd0);
        check("rst_rgb",  d1_rgb, TR);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C);
        for (int i = 0; i < 6; i++) frame(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1C);
        check("rerun_done", {7'd0, d1_done}, 8'd1);
        idle_cyc(2);

        // Endless run on the BLINK_COUNT=0 instance over 30 frames.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
        for (int i = 0; i < 30; i++) begin
            frame(1'b0, 1'b0);
            check("endless_busy", {7'd0, d0_busy}, 8'd1);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C);
        check("endless_stop", {7'd0, d0_busy}, 8'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                1'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/word_blinker.md
WORD_BLINKER -- requirements
Module: word_blinker

Interface
REQ-001 SHALL have parameter ON_FRAMES, default 30, number of frames the word is visible per blink period (1..255).
REQ-002 SHALL have parameter OFF_FRAMES, default 15, number of frames the word is hidden per blink period (1..255).
REQ-003 SHALL have parameter BLINK_COUNT, default 5, number of ON/OFF periods per run (0..15); 0 means blink until stopped.
REQ-004 SHALL have port clk, input, 1, sole clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port startOfFrame, input, 1, one-cycle pulse at the first pixel of each frame.
REQ-007 SHALL have port trigger, input, 1, one-cycle request to start a blink run.
REQ-008 SHALL have port stop, input, 1, one-cycle request to abort a run.
REQ-009 SHALL have port drawWord, input, 1, word-layer draw request for the current pixel.
REQ-010 SHALL have port RGBWord, input, 8, word-layer colour for the current pixel.
REQ-011 SHALL have port drawWordOut, output, 1, gated draw request.
REQ-012 SHALL have port RGBWordOut, output, 8, gated colour.
REQ-013 SHALL have port busy, output, 1, high while a run is active.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a finite run completes.

Function
REQ-015 SHALL implement FSM states IDLE, ARM, ON, OFF, plus an 8-bit frame counter and a 4-bit blink counter.
REQ-016 IDLE: trigger moves the FSM to ARM; all other inputs are ignored.
REQ-017 ARM: on startOfFrame, the FSM SHALL move to ON and clear both counters, so visibility always begins on a frame boundary.
REQ-018 ON: on each startOfFrame, if frameCnt == ON_FRAMES-1 the FSM SHALL go to OFF with frameCnt cleared; otherwise frameCnt increments.
REQ-019 OFF: on each startOfFrame, if frameCnt != OFF_FRAMES-1 frameCnt SHALL increment.
REQ-020 OFF: on the startOfFrame where frameCnt == OFF_FRAMES-1, frameCnt SHALL clear; if BLINK_COUNT != 0 and blinkCnt == BLINK_COUNT-1, the FSM SHALL go to IDLE and pulse done for that one cycle; otherwise blinkCnt increments and the FSM goes to ON.
REQ-021 With BLINK_COUNT == 0, blinkCnt SHALL hold at 0 and the FSM SHALL never exit to IDLE except by stop or reset.
REQ-022 stop in ARM, ON or OFF SHALL force IDLE on the next edge, clear both counters, and produce no done pulse.
REQ-023 stop SHALL take priority over a simultaneous startOfFrame or trigger.
REQ-024 trigger outside IDLE SHALL be ignored (no restart, no counter change).
REQ-025 trigger and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-026 drawWordOut SHALL be registered: drawWordOut(n+1) = drawWord(n) AND (state(n) == ON); latency is exactly 1 cycle.
REQ-027 RGBWordOut SHALL be registered: RGBWordOut(n+1) = RGBWord(n) when the gate in REQ-026 is true, else COLOR_TRANSPARENT from the defines package.
REQ-028 busy SHALL be combinational: high when state != IDLE.
REQ-029 done SHALL be registered and high for exactly one cycle per completed finite run.
REQ-030 Counter compares SHALL be exact equality at parameter width; counters never wrap in normal operation.

Reset
REQ-031 On reset high at a clk edge: state = IDLE, frameCnt = 0, blinkCnt = 0, drawWordOut = 0, RGBWordOut = COLOR_TRANSPARENT, done = 0.
REQ-032 Reset mid-run SHALL abort with no done pulse; reset SHALL take priority over stop, trigger and startOfFrame.

Verification (ON_FRAMES=2, OFF_FRAMES=1, BLINK_COUNT=2 unless noted)
REQ-033 trigger, then 7 startOfFrame pulses with drawWord=1 and RGBWord=8'h1C -> states ARM,ON,ON,OFF,ON,ON,OFF,IDLE; drawWordOut=1 and RGBWordOut=8'h1C only during ON frames (1 cycle late); single done pulse after the 7th pulse; busy low afterwards.
REQ-034 stop in the 2nd ON frame -> IDLE next cycle, busy=0, done never pulses, drawWordOut=0 from the following cycle.
REQ-035 trigger while in OFF -> no effect; the run ends after the same 7 frames as REQ-033.
REQ-036 stop and startOfFrame asserted in the same ON cycle -> IDLE, no transition to OFF.
REQ-037 BLINK_COUNT=0, 30 frames -> ON/OFF alternation continues (2 on, 1 off), done never pulses, busy stays 1.
REQ-038 reset asserted in OFF -> all outputs at reset values next cycle; subsequent trigger restarts a full run from ARM.
